vga_band_fetch: RTL and testbench
=================================

Name: vga_band_fetch

Overview:
- Parametrised pixel fetch engine between the VGA timing counters and the colour DAC outputs.
- Maps the active raster onto BANDS horizontal image bands, each stored in its own external memory bank.
- Generates linear read addresses with an accumulator, so no multiplier is needed.
- Aligns the returned RGB data and display enable through a fixed-latency pipeline, and adds frame-synchronous test-pattern modes.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_TOTAL, 1040, total clocks per line
- V_ACTIVE, 600, visible lines per frame
- V_TOTAL, 666, total lines per frame
- BANDS, 4, number of image bands/banks; V_ACTIVE must equal BANDS*BAND_LINES
- BAND_LINES, 150, lines per band
- COLOR_W, 8, bits per colour channel
- ADDR_W, 17, bank address width; 2^ADDR_W must be at least H_ACTIVE*BAND_LINES
- MEM_LAT, 2, bank read latency in clocks, minimum 1
- BAND_W, 2, width of bank select; 2^BAND_W must be at least BANDS

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- h_count  in  11  horizontal counter, 0..H_TOTAL-1
- v_count  in  10  vertical counter, 0..V_TOTAL-1
- mode  in  2  0 image, 1 solid, 2 colour bars, 3 checkerboard
- solid_rgb  in  3*COLOR_W  {R,G,B} colour for mode 1
- mem_rd  out  1  bank read strobe
- mem_band  out  BAND_W  bank select
- mem_addr  out  ADDR_W  address within the bank
- mem_rdata  in  3*COLOR_W  {R,G,B}, valid MEM_LAT clocks after mem_rd
- red, green, blue  out  COLOR_W each  pixel colour
- de  out  1  display enable aligned to the colour outputs
- frame_start  out  1  one-clock pulse when the new frame's settings take effect

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - red, green, blue, de, mem_rd, mem_addr, mem_band, frame_start = 0.
  - Internal state cleared: band=0, line_in_band=0, line_base=0, mode_q=0, synced=0.
  - Pipeline stages flushed.
- active = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- Frame boundary FB = (h_count == H_TOTAL-1) && (v_count == V_TOTAL-1). At FB:
  - band, line_in_band and line_base are set to 0.
  - mode_q is loaded from mode.
  - synced is set to 1.
  - frame_start pulses on the following clock.
- End of active line EOL = (h_count == H_TOTAL-1) && (v_count < V_ACTIVE). At EOL:
  - If line_in_band == BAND_LINES-1: band increments, line_in_band=0, line_base=0.
  - Otherwise: line_in_band increments, line_base += H_ACTIVE.
  - Every active line is fetched; no line is skipped at a band boundary.
- Fetch stage (registered every clk):
  - mem_rd = active && synced && (mode_q == 0).
  - mem_addr = line_base + h_count, truncated to ADDR_W.
  - mem_band = band.
  - mem_addr and mem_band update only when mem_rd is 1; otherwise they hold.
- Alignment pipeline: active&&synced, mode_q and the pattern colour are delayed MEM_LAT clocks to meet mem_rdata.
- Output register:
  - Pixel for counters (h, v) sampled at edge k appears on the outputs after edge k+MEM_LAT+1.
  - de follows with the same latency.
- Colour selection:
  - de=0: outputs 0.
  - Mode 0: mem_rdata.
  - Mode 1: solid_rgb.
  - Mode 2: eight equal-width bars, index = number of boundaries h_count has crossed, boundaries at multiples of H_ACTIVE/8. Order: white, yellow, cyan, green, magenta, red, blue, black. Full scale = all ones.
  - Mode 3: white when h_count[5]^v_count[5] is 1, else black.
- Mode changes mid-frame have no effect until the next FB; there is no tearing.
- After reset, de and mem_rd stay 0 until the first FB has been seen. This holds even if the counters are mid-frame.
- Counter values of H_TOTAL or above are treated as blanking; state does not advance.

Test Plan:
- Reset, then free-running counters, mode=0 → de=0 and mem_rd=0 through the first partial frame; frame_start pulses once after the FB clock; first active pixel (0,0) gives mem_addr=0, band=0; mem_rdata appears on red/green/blue exactly MEM_LAT+1 clocks after h=0 is sampled.
- Line 149 to line 150 → last address of band 0 is 119999; line 150 pixel 0 gives band=1, addr=0 (no skipped line); line 599 pixel 799 gives band=3, addr=119999.
- Blanking (h=800..1039, v=600..665) → de=0, outputs 0, mem_rd=0.
- Mode written to 2 at v=300 → image continues to frame end; the next frame shows bars, e.g. h=0 white, h=100 yellow, h=799 black; mem_rd stays 0.
- Mode 1 with solid_rgb=24'h12_34_56 → every active pixel gives R=0x12, G=0x34, B=0x56; mode 3 at (32,0) → white, at (32,32) → black.
- rst_n=0 for one clock at h=400, v=200 → outputs clear on the next edge; de stays 0 until after the next FB, then resumes with addr=0, band=0.

Source files
------------

// File: rtl/vga_band_fetch.sv
// Pixel fetch engine: walks the active raster across BANDS memory banks with an
// accumulated line base, and aligns bank data or test patterns to the DAC outputs.
module vga_band_fetch #(
  parameter int H_ACTIVE   = 800,
  parameter int H_TOTAL    = 1040,
  parameter int V_ACTIVE   = 600,
  parameter int V_TOTAL    = 666,
  parameter int BANDS      = 4,
  parameter int BAND_LINES = 150,
  parameter int COLOR_W    = 8,
  parameter int ADDR_W     = 17,
  parameter int MEM_LAT    = 2,
  parameter int BAND_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            h_count,
  input  logic [9:0]             v_count,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   mem_rd,
  output logic [BAND_W-1:0]      mem_band,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [3*COLOR_W-1:0]   mem_rdata,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   de,
  output logic                   frame_start
);

  localparam int LIB_W = (BAND_LINES > 1) ? $clog2(BAND_LINES) : 1;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int PW    = 3 * COLOR_W;
  localparam logic [10:0]       H_ACT     = 11'(H_ACTIVE);
  localparam logic [10:0]       H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [9:0]        V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]        V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [LIB_W-1:0]  LIB_LAST  = LIB_W'(BAND_LINES - 1);
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(BANDS - 1);

  logic              active, fb, eol, fetch;
  logic [BAND_W-1:0] band;
  logic [LIB_W-1:0]  line_in_band;
  logic [ADDR_W-1:0] line_base;
  logic [1:0]        mode_q;
  logic              synced;

  logic [2:0]        bar_idx;
  logic [2:0]        bar_rgb;
  logic [PW-1:0]     pattern;

  logic [MEM_LAT:0]  vld_pipe;
  logic [MEM_LAT:0]  img_pipe;
  logic [PW-1:0]     pat_pipe [MEM_LAT+1];

  assign active = (h_count < H_ACT) && (v_count < V_ACT);
  assign fb     = (h_count == H_LAST) && (v_count == V_LAST);
  assign eol    = (h_count == H_LAST) && (v_count < V_ACT);
  assign fetch  = active && synced && (mode_q == 2'd0);

  // Bar index counts crossed boundaries, avoiding a divider on h_count.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_count >= 11'(i * BAR_W)) bar_idx = bar_idx + 3'd1;
    end
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
    pattern = '0;
    case (mode_q)
      2'd1:    pattern = solid_rgb;
      2'd2:    pattern = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};
      2'd3:    if (h_count[5] ^ v_count[5]) pattern = '1;
      default: pattern = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      band         <= '0;
      line_in_band <= '0;
      line_base    <= '0;
      mode_q       <= 2'd0;
      synced       <= 1'b0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      mem_band     <= '0;
      frame_start  <= 1'b0;
      vld_pipe     <= '0;
      img_pipe     <= '0;
      for (int i = 0; i <= MEM_LAT; i++) pat_pipe[i] <= '0;
      de           <= 1'b0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
    end else begin
      frame_start <= fb;
      mem_rd      <= fetch;
      if (fetch) begin
        mem_addr <= line_base + ADDR_W'(h_count);
        mem_band <= band;
      end

      vld_pipe    <= {vld_pipe[MEM_LAT-1:0], active && synced};
      img_pipe    <= {img_pipe[MEM_LAT-1:0], mode_q == 2'd0};
      pat_pipe[0] <= pattern;
      for (int i = 1; i <= MEM_LAT; i++) pat_pipe[i] <= pat_pipe[i-1];

      de <= vld_pipe[MEM_LAT];
      if (!vld_pipe[MEM_LAT])     {red, green, blue} <= '0;
      else if (img_pipe[MEM_LAT]) {red, green, blue} <= mem_rdata;
      else                        {red, green, blue} <= pat_pipe[MEM_LAT];

      // Settings only change at the frame boundary so a frame never tears.
      if (fb) begin
        band         <= '0;
        line_in_band <= '0;
        line_base    <= '0;
        mode_q       <= mode;
        synced       <= 1'b1;
      end else if (eol) begin
        if (line_in_band == LIB_LAST) begin
          band         <= (band == BAND_LAST) ? '0 : band + BAND_W'(1);
          line_in_band <= '0;
          line_base    <= '0;
        end else begin
          line_in_band <= line_in_band + LIB_W'(1);
          line_base    <= line_base + ADDR_W'(H_ACTIVE);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_band_fetch.sv
// Bench for vga_band_fetch: drives sparse raster samples, models banks that return
// {band, addr}, and scoreboards every output pixel against an independent model.
module tb_vga_band_fetch;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic        mem_rd;
  logic [1:0]  mem_band;
  logic [16:0] mem_addr;
  logic [23:0] mem_rdata;
  logic [7:0]  red, green, blue;
  logic        de;
  logic        frame_start;

  always #5 clk = ~clk;

  vga_band_fetch dut (
    .clk(clk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
    .mode(mode), .solid_rgb(solid_rgb), .mem_rd(mem_rd), .mem_band(mem_band),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .red(red), .green(green),
    .blue(blue), .de(de), .frame_start(frame_start)
  );

  // Bank model: fixed latency, data encodes the requested location.
  logic [23:0] mpipe [MEM_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mem_rd ? {5'd0, mem_band, mem_addr} : 24'hA5A5A5;
    for (int i = 1; i < MEM_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mem_rdata = mpipe[MEM_LAT-1];

  typedef struct {
    logic        de;
    logic [23:0] rgb;
    int          h;
    int          v;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          syn_m;
  logic [1:0]  mode_m;
  logic [16:0] addr_m;
  logic [1:0]  band_m;
  int          rd_count, de_count, fs_count;
  logic [23:0] seen [int];
  logic        seen_de [int];
  logic [18:0] snap [4];
  logic        rst_de;
  logic [23:0] rst_rgb;
  int          hl [13] = '{0, 1, 31, 32, 33, 99, 100, 101, 399, 400, 700, 798, 799};

  function automatic logic [23:0] pix(int h, int v, logic [1:0] m);
    case (m)
      2'd0: return {5'd0, 2'(v / 150), 17'((v % 150) * 800 + h)};
      2'd1: return solid_rgb;
      2'd2: begin
        case (h / 100)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      default: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  function automatic int key(int h, int v);
    return v * 2048 + h;
  endfunction

  task automatic tick();
    int   h, v;
    bit   act, fb, exp_rd, exp_fs;
    exp_t e, p;
    h = int'(h_count);
    v = int'(v_count);
    act = (h < 800) && (v < 600);
    fb = (h == 1039) && (v == 665);
    exp_rd = rst_n && act && syn_m && (mode_m == 2'd0);
    exp_fs = rst_n && fb;
    e.h = h;
    e.v = v;
    e.de = rst_n && act && syn_m;
    e.rgb = e.de ? pix(h, v, mode_m) : 24'h0;
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i <= MEM_LAT; i++) q.push_back('{1'b0, 24'h0, -1, -1});
    end
    q.push_back(e);
    if (!rst_n) begin
      syn_m = 1'b0; mode_m = 2'd0; addr_m = '0; band_m = '0;
    end else begin
      if (exp_rd) begin
        addr_m = 17'((v % 150) * 800 + h);
        band_m = 2'(v / 150);
      end
      if (fb) begin
        syn_m = 1'b1;
        mode_m = mode;
      end
    end
    @(posedge clk);
    #1;
    if (q.size() > MEM_LAT + 1) begin
      p = q.pop_front();
      checks++;
      if (de !== p.de || {red, green, blue} !== p.rgb) begin
        errors++;
        $display("FAIL pixel (%0d,%0d): got de=%b rgb=%h, expected de=%b rgb=%h",
                 p.h, p.v, de, {red, green, blue}, p.de, p.rgb);
      end
      if (p.v >= 0) begin
        seen[key(p.h, p.v)] = {red, green, blue};
        seen_de[key(p.h, p.v)] = de;
      end
    end
    checks++;
    if (mem_rd !== exp_rd) begin
      errors++;
      $display("FAIL mem_rd at (%0d,%0d): got %b, expected %b", h, v, mem_rd, exp_rd);
    end
    checks++;
    if (mem_addr !== addr_m || mem_band !== band_m) begin
      errors++;
      $display("FAIL mem_addr at (%0d,%0d): got band=%0d addr=%0d, expected band=%0d addr=%0d",
               h, v, mem_band, mem_addr, band_m, addr_m);
    end
    checks++;
    if (frame_start !== exp_fs) begin
      errors++;
      $display("FAIL frame_start at (%0d,%0d): got %b, expected %b", h, v, frame_start, exp_fs);
    end
    if (mem_rd) rd_count++;
    if (de) de_count++;
    if (frame_start) fs_count++;
  endtask

  task automatic drive_px(int h, int v, int rst_v);
    h_count = 11'(h);
    if (v == rst_v && h == 400) begin
      rst_n = 1'b0;
      tick();
      rst_de = de;
      rst_rgb = {red, green, blue};
      rst_n = 1'b1;
    end else begin
      tick();
    end
    if (h == 0 && v == 0)     snap[0] = {mem_band, mem_addr};
    if (h == 799 && v == 149) snap[1] = {mem_band, mem_addr};
    if (h == 0 && v == 150)   snap[2] = {mem_band, mem_addr};
    if (h == 799 && v == 599) snap[3] = {mem_band, mem_addr};
  endtask

  task automatic run_frame(int v0, int v_end, int chg_v, logic [1:0] chg_mode, int rst_v, bit full);
    seen.delete();
    seen_de.delete();
    for (int i = 0; i < 4; i++) snap[i] = '1;
    rd_count = 0;
    de_count = 0;
    for (int v = v0; v <= v_end; v++) begin
      v_count = 10'(v);
      if (v == chg_v) mode = chg_mode;
      if (v < 600) begin
        if (full && (v == 0 || v == 149 || v == 150 || v == 599)) begin
          for (int h = 0; h < 800; h++) drive_px(h, v, rst_v);
        end else begin
          foreach (hl[i]) drive_px(hl[i], v, rst_v);
        end
        if (v == 10) begin h_count = 11'd1100; tick(); end
        h_count = 11'd800;  tick();
        h_count = 11'd1039; tick();
      end else begin
        h_count = 11'd0; tick();
        if (v == 640) begin h_count = 11'd2047; tick(); end
        h_count = 11'd1039; tick();
      end
    end
  endtask

  task automatic chk_px(string name, int h, int v, logic [23:0] exp_rgb);
    checks++;
    if (!seen.exists(key(h, v)) || seen[key(h, v)] !== exp_rgb || seen_de[key(h, v)] !== 1'b1) begin
      errors++;
      $display("FAIL %s (%0d,%0d): got rgb=%h de=%b, expected rgb=%h de=1", name, h, v,
               seen.exists(key(h, v)) ? seen[key(h, v)] : 24'hxxxxxx,
               seen_de.exists(key(h, v)) ? seen_de[key(h, v)] : 1'bx, exp_rgb);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'd0; solid_rgb = 24'h0;
    h_count = 11'd400; v_count = 10'd300;
    tick();
    tick();
    checks++;
    if (de !== 1'b0 || mem_rd !== 1'b0 || frame_start !== 1'b0 || {red, green, blue} !== 24'h0 ||
        mem_addr !== 17'd0 || mem_band !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: de=%b rd=%b fs=%b rgb=%h addr=%0d band=%0d, expected all 0",
               de, mem_rd, frame_start, {red, green, blue}, mem_addr, mem_band);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_partial_frame();
    fs_count = 0;
    run_frame(300, 665, -1, 2'd0, -1, 1'b0);
    checks++;
    if (rd_count != 0 || de_count != 0) begin
      errors++;
      $display("FAIL unsynced_quiet: rd_count=%0d de_count=%0d, expected 0 and 0", rd_count, de_count);
    end
    checks++;
    if (fs_count != 1) begin
      errors++;
      $display("FAIL frame_start_count: got %0d, expected 1", fs_count);
    end
  endtask

  task automatic test_image_and_bands();
    run_frame(0, 665, 300, 2'd2, -1, 1'b1);
    checks++;
    if (snap[0] !== {2'd0, 17'd0} || snap[1] !== {2'd0, 17'd119999}) begin
      errors++;
      $display("FAIL band0_addr: first=%h last=%h, expected %h %h", snap[0], snap[1],
               {2'd0, 17'd0}, {2'd0, 17'd119999});
    end
    checks++;
    if (snap[2] !== {2'd1, 17'd0} || snap[3] !== {2'd3, 17'd119999}) begin
      errors++;
      $display("FAIL band_cross_addr: line150=%h line599=%h, expected %h %h", snap[2], snap[3],
               {2'd1, 17'd0}, {2'd3, 17'd119999});
    end
    chk_px("image_first", 1, 0, 24'h000001);
    chk_px("image_b0_last", 799, 149, 24'h01D4BF);
    chk_px("image_b1_first", 0, 150, 24'h020000);
    chk_px("image_b3_last", 799, 599, 24'h07D4BF);
    chk_px("image_after_mode_write", 400, 400, 24'h053A10);
  endtask

  task automatic test_bars();
    solid_rgb = 24'h123456;
    run_frame(0, 665, 300, 2'd1, -1, 1'b0);
    checks++;
    if (rd_count != 0) begin
      errors++;
      $display("FAIL bars_no_reads: rd_count=%0d, expected 0", rd_count);
    end
    chk_px("bar_white", 0, 20, 24'hFFFFFF);
    chk_px("bar_yellow", 100, 20, 24'hFFFF00);
    chk_px("bar_magenta", 400, 450, 24'hFF00FF);
    chk_px("bar_black", 799, 599, 24'h000000);
  endtask

  task automatic test_solid();
    run_frame(0, 665, 300, 2'd3, -1, 1'b0);
    chk_px("solid_mid", 400, 300, 24'h123456);
    chk_px("solid_corner", 799, 599, 24'h123456);
  endtask

  task automatic test_checker();
    run_frame(0, 665, 300, 2'd0, -1, 1'b0);
    chk_px("checker_32_0", 32, 0, 24'hFFFFFF);
    chk_px("checker_32_32", 32, 32, 24'h000000);
    chk_px("checker_0_32", 0, 32, 24'hFFFFFF);
  endtask

  task automatic test_mid_reset();
    rst_de = 1'b1;
    rst_rgb = 24'hFFFFFF;
    run_frame(0, 665, -1, 2'd0, 200, 1'b0);
    checks++;
    if (rst_de !== 1'b0 || rst_rgb !== 24'h0) begin
      errors++;
      $display("FAIL reset_clears_outputs: de=%b rgb=%h, expected 0 0", rst_de, rst_rgb);
    end
    chk_px("before_reset", 1, 0, 24'h000001);
    checks++;
    if (!seen_de.exists(key(400, 300)) || seen_de[key(400, 300)] !== 1'b0) begin
      errors++;
      $display("FAIL de_after_reset: got %b, expected 0",
               seen_de.exists(key(400, 300)) ? seen_de[key(400, 300)] : 1'bx);
    end
    run_frame(0, 2, -1, 2'd0, -1, 1'b0);
    checks++;
    if (snap[0] !== {2'd0, 17'd0}) begin
      errors++;
      $display("FAIL resume_addr: got %h, expected %h", snap[0], {2'd0, 17'd0});
    end
    chk_px("resume_pixel", 1, 0, 24'h000001);
  endtask

  initial begin
    syn_m = 1'b0; mode_m = 2'd0; addr_m = '0; band_m = '0;
    rd_count = 0; de_count = 0; fs_count = 0;
    test_reset();
    test_first_partial_frame();
    test_image_and_bands();
    test_bars();
    test_solid();
    test_checker();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
